muldiv_seq: RTL

- Multi-cycle RV32M multiply/divide responder.
- Execute stage issues an operation over a valid/ready request channel; block returns a 32-bit result over a valid/ready response channel.
- Replaces the combinational multiply/divide path so the execute stage meets timing.
- Execute stage stalls while a request is outstanding.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_negate.sv | 12 +
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and the special-case result values.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and sign correction.
module muldiv_negate #(
    parameter int unsigned Width = 64
) (
    input  logic             neg,
    input  logic [Width-1:0] in_val,
    output logic [Width-1:0] out_val
);

    assign out_val = neg ? (~in_val + Width'(1)) : in_val;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide responder: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int unsigned CW = $clog2(ITER);

    state_e            state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   resp_data_q;
    logic              resp_valid_q, req_ready_q, busy_q;

    // Operand signs, magnitudes and special cases, evaluated on the incoming request
    logic            sa, sb, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (req_op)
            MD_MULH, MD_DIV, MD_REM: begin
                sa = req_a[XLEN-1];
                sb = req_b[XLEN-1];
            end
            MD_MULHSU: sa = req_a[XLEN-1];
            default: ;
        endcase
    end

    assign neg_in = (req_op == MD_REM) ? sa : (sa ^ sb);

    muldiv_negate #(.Width(XLEN)) u_neg_a (.neg(sa), .in_val(req_a), .out_val(a_mag));
    muldiv_negate #(.Width(XLEN)) u_neg_b (.neg(sb), .in_val(req_b), .out_val(b_mag));

    assign div_by_zero = req_op[2] && (req_b == '0);
    assign div_ovf     = ((req_op == MD_DIV) || (req_op == MD_REM)) &&
                         (req_a == INT_MIN) && (req_b == '1);
    assign special_res = div_by_zero ? (req_op[1] ? req_a : DIV_BY_ZERO_Q)
                                     : (req_op[1] ? '0 : INT_MIN);

    logic            fast_hit;
    logic [XLEN-1:0] fast_res;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{(XLEN-1){sa}}, sa, req_a};
    assign fast_b    = {{(XLEN-1){sb}}, sb, req_b};
    assign fast_prod = fast_a * fast_b;
    assign fast_hit  = !req_op[2];
    assign fast_res  = (req_op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    // One iteration step. acc_q holds {accumulator, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_step, raw_res, corr_res;
    logic [XLEN-1:0]   result;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = !div_diff[XLEN];

    always_comb begin
        if (op_q[2]) begin
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
            raw_res  = {{XLEN{1'b0}}, (op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0])};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
            raw_res  = acc_step;
        end
    end

    muldiv_negate #(.Width(2*XLEN)) u_neg_res (.neg(neg_q), .in_val(raw_res), .out_val(corr_res));

    assign result = ((op_q == MD_MUL) || op_q[2]) ? corr_res[XLEN-1:0]
                                                  : corr_res[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            opb_q        <= '0;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && !kill) begin
                        op_q        <= req_op;
                        neg_q       <= neg_in;
                        acc_q       <= {{XLEN{1'b0}}, a_mag};
                        opb_q       <= b_mag;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (div_by_zero || div_ovf) begin
                            state_q      <= ST_DONE;
                            resp_data_q  <= special_res;
                            resp_valid_q <= 1'b1;
                        end else if (fast_hit) begin
                            state_q      <= ST_DONE;
                            resp_data_q  <= fast_res;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(ITER - 1)) begin
                            state_q      <= ST_DONE;
                            resp_data_q  <= result;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (kill || resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;

endmodule
